// File: rtl/rtc_bus_if.sv
// Multiplexed RTC AD bus: strobes and drive value from the controller, read value back from the RTC.
interface rtc_bus_if;
  logic       ad;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [7:0] adout;
  logic       ad_oe;
  logic [7:0] adin;

  modport master (output ad, cs, wr, rd, adout, ad_oe, input adin);
  modport slave  (input ad, cs, wr, rd, adout, ad_oe, output adin);
endinterface

// File: rtl/rtc_read_burst.sv
// Reads NREG consecutive RTC registers over the multiplexed AD bus and publishes
// all captured bytes at once on rdata when the burst completes.
module rtc_read_burst #(
  parameter int         NREG      = 3,
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         T_HOLD    = 5,
  parameter int         T_GAP     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  rtc_bus_if.master           bus,
  output logic                busy,
  output logic                done,
  output logic                valid,
  output logic [8*NREG-1:0]   rdata
);

  typedef enum logic [3:0] {
    IDLE, A_AD, A_CS, A_WR, A_WRH, A_CSH, A_ADH, GAP1,
    R_CS, R_RD, R_RDH, R_CSH, GAP2, DONE
  } state_t;

  localparam int TMAX = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(T_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREG - 1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IW-1:0]     index_reg, index_next;
  logic              capture;
  logic [7:0]        shadow_reg [NREG];
  logic [8*NREG-1:0] shadow_flat;

  logic       ad_reg, cs_reg, wr_reg, rd_reg, oe_reg;
  logic       ad_next, cs_next, wr_next, rd_next, oe_next;
  logic [7:0] adout_reg, adout_next, addr_next;
  logic       busy_reg, done_reg, valid_reg;
  logic [8*NREG-1:0] rdata_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    index_next = index_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = A_AD;
      A_AD:  state_next = A_CS;
      A_CS:  state_next = A_WR;
      A_WR:  if (cnt_reg == HOLD_LAST) state_next = A_WRH;
             else cnt_next = cnt_reg + 1'b1;
      A_WRH: state_next = A_CSH;
      A_CSH: state_next = A_ADH;
      A_ADH: state_next = GAP1;
      GAP1:  if (cnt_reg == GAP_LAST) state_next = R_CS;
             else cnt_next = cnt_reg + 1'b1;
      R_CS:  state_next = R_RD;
      R_RD:  if (cnt_reg == HOLD_LAST) begin
               capture    = 1'b1;
               state_next = R_RDH;
             end else cnt_next = cnt_reg + 1'b1;
      R_RDH: state_next = R_CSH;
      R_CSH: state_next = GAP2;
      GAP2:  if (cnt_reg == GAP_LAST) begin
               if (index_reg == LAST_IDX) state_next = DONE;
               else begin
                 index_next = index_reg + 1'b1;
                 state_next = A_AD;
               end
             end else cnt_next = cnt_reg + 1'b1;
      DONE:  begin
               state_next = IDLE;
               index_next = '0;
             end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  assign addr_next = BASE_ADDR + 8'(index_next);

  always_comb begin
    ad_next    = 1'b1;
    cs_next    = 1'b1;
    wr_next    = 1'b1;
    rd_next    = 1'b1;
    adout_next = 8'hFF;
    oe_next    = 1'b0;
    case (state_next)
      A_AD:  ad_next = 1'b0;
      A_CS:  begin ad_next = 1'b0; cs_next = 1'b0; end
      A_WR:  begin
               ad_next = 1'b0; cs_next = 1'b0; wr_next = 1'b0;
               adout_next = addr_next; oe_next = 1'b1;
             end
      A_WRH: begin ad_next = 1'b0; cs_next = 1'b0; adout_next = addr_next; oe_next = 1'b1; end
      A_CSH: begin ad_next = 1'b0; adout_next = addr_next; oe_next = 1'b1; end
      R_CS:  cs_next = 1'b0;
      R_RD:  begin cs_next = 1'b0; rd_next = 1'b0; end
      R_RDH: cs_next = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      index_reg <= '0;
      ad_reg    <= 1'b1;
      cs_reg    <= 1'b1;
      wr_reg    <= 1'b1;
      rd_reg    <= 1'b1;
      adout_reg <= 8'hFF;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      index_reg <= index_next;
      ad_reg    <= ad_next;
      cs_reg    <= cs_next;
      wr_reg    <= wr_next;
      rd_reg    <= rd_next;
      adout_reg <= adout_next;
      oe_reg    <= oe_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      if (state_next == DONE) begin
        valid_reg <= 1'b1;
        rdata_reg <= shadow_flat;
      end
    end
  end

  // Shadow bytes need no reset: every byte is rewritten before rdata is loaded.
  always_ff @(posedge clock) begin
    if (capture) shadow_reg[index_reg] <= bus.adin;
  end

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
      assign shadow_flat[8*gi +: 8] = shadow_reg[gi];
    end
  endgenerate

  assign bus.ad    = ad_reg;
  assign bus.cs    = cs_reg;
  assign bus.wr    = wr_reg;
  assign bus.rd    = rd_reg;
  assign bus.adout = adout_reg;
  assign bus.ad_oe = oe_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign valid     = valid_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_rtc_read_burst.sv
// Bench for rtc_read_burst: default-parameter burst table, mid-burst reset, and an
// address-wrap instance (NREG=2, BASE_ADDR=FF) against a behavioural RTC model.
module tb_rtc_read_burst;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        busy1, done1, valid1;
  logic        busy2, done2, valid2;
  logic [23:0] rdata1;
  logic [15:0] rdata2;

  int n_applied = 0;
  int n_miss    = 0;

  always #5 clock = ~clock;

  rtc_bus_if bus1 ();
  rtc_bus_if bus2 ();

  rtc_read_burst dut1 (
    .clock(clock), .reset(reset), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .valid(valid1), .rdata(rdata1)
  );

  rtc_read_burst #(.NREG(2), .BASE_ADDR(8'hFF), .T_HOLD(2), .T_GAP(3)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .valid(valid2), .rdata(rdata2)
  );

  // RTC model: latch the address during the address-write strobe, return mem[addr] while rd is low.
  logic [7:0] mem [256];
  logic [7:0] lat1 = 8'h00;
  logic [7:0] lat2 = 8'h00;

  always @(posedge clock) begin
    if (!bus1.cs && !bus1.wr && !bus1.ad) lat1 <= bus1.adout;
    if (!bus2.cs && !bus2.wr && !bus2.ad) lat2 <= bus2.adout;
  end

  assign bus1.adin = bus1.rd ? 8'hEE : mem[lat1];
  assign bus2.adin = bus2.rd ? 8'hEE : mem[lat2];

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp;
    bit          mid;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input int id);
    int done_cyc = -1;
    int n_done = 0, n_wr = 0, bad_len = 0, bad_addr = 0, viol = 0, wr_run = 0;
    logic [7:0]  exp_addr [3];
    logic [23:0] prev;
    exp_addr = '{8'h21, 8'h22, 8'h23};
    mem[8'h21] = v.b0;
    mem[8'h22] = v.b1;
    mem[8'h23] = v.b2;
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
    prev = rdata1;
    for (int c = 0; c < 120; c++) begin
      if (c > 0) @(negedge clock);
      start1 = (v.mid && c == 40);
      if (!bus1.wr) begin
        if (wr_run == 0) begin
          if (n_wr < 3 && bus1.adout !== exp_addr[n_wr]) bad_addr++;
          n_wr++;
        end
        wr_run++;
        if (bus1.ad !== 1'b0 || bus1.ad_oe !== 1'b1) viol++;
      end else begin
        if (wr_run != 0 && wr_run != 5) bad_len++;
        wr_run = 0;
      end
      if (!bus1.rd && (bus1.ad !== 1'b1 || bus1.ad_oe !== 1'b0 || bus1.cs !== 1'b0)) viol++;
      if (!bus1.rd && !bus1.wr) viol++;
      if (done1) begin
        n_done++;
        done_cyc = c;
      end
      if (rdata1 !== prev && !done1) viol++;
      prev = rdata1;
    end
    start1 = 1'b0;
    check("done_latency", done_cyc, 102);
    check("done_count", n_done, 1);
    check("wr_pulses", n_wr, 3);
    check("wr_len_bad", bad_len, 0);
    check("wr_addr_bad", bad_addr, 0);
    check("bus_protocol", viol, 0);
    check("rdata", rdata1, v.exp);
    check("valid", valid1, 1);
    check("busy_after", busy1, 0);
    $display("burst %0d: rdata=%h expected=%h done_at=%0d wr_pulses=%0d", id, rdata1, v.exp, done_cyc, n_wr);
  endtask

  initial begin
    int falls, n_bad;
    logic rd_prev;
    int done_cyc2, n_wr2, wr_run2, bad_len2;
    logic [7:0] a2 [2];

    vecs[0] = '{b0: 8'h45, b1: 8'h30, b2: 8'h12, exp: 24'h123045, mid: 1'b0};
    vecs[1] = '{b0: 8'hA7, b1: 8'h00, b2: 8'hFF, exp: 24'hFF00A7, mid: 1'b1};
    vecs[2] = '{b0: 8'h5C, b1: 8'hE1, b2: 8'h3B, exp: 24'h3BE15C, mid: 1'b0};
    vecs[3] = '{b0: 8'h11, b1: 8'h22, b2: 8'h33, exp: 24'h332211, mid: 1'b0};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    // Reset and idle
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_strobes", {bus1.ad, bus1.cs, bus1.wr, bus1.rd}, 4'hF);
    check("idle_adout", bus1.adout, 8'hFF);
    check("idle_ad_oe", bus1.ad_oe, 0);
    check("idle_busy", busy1, 0);
    check("idle_done", done1, 0);
    check("idle_valid", valid1, 0);
    check("idle_rdata", rdata1, 0);
    check("idle_rdata2", rdata2, 0);
    $display("reset: strobes=%b adout=%h rdata=%h", {bus1.ad, bus1.cs, bus1.wr, bus1.rd}, bus1.adout, rdata1);

    for (int i = 0; i < 3; i++) run_burst(vecs[i], i);

    // Reset during the read strobe of the second register
    @(negedge clock) start1 = 1'b1;
    @(negedge clock) start1 = 1'b0;
    falls = 0;
    rd_prev = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (!bus1.rd && rd_prev) falls++;
      rd_prev = bus1.rd;
      if (falls == 2) break;
      @(negedge clock);
    end
    check("reach_rrd2", falls, 2);
    check("in_rrd2_rd", bus1.rd, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_strobes", {bus1.ad, bus1.cs, bus1.wr, bus1.rd}, 4'hF);
    check("rst_adout", bus1.adout, 8'hFF);
    check("rst_ad_oe", bus1.ad_oe, 0);
    check("rst_busy", busy1, 0);
    check("rst_valid", valid1, 0);
    check("rst_rdata", rdata1, 0);
    n_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done1 || busy1) n_bad++;
    end
    check("rst_quiet", n_bad, 0);
    $display("midburst reset: valid=%b rdata=%h busy=%b", valid1, rdata1, busy1);

    run_burst(vecs[3], 3);

    // Address wrap instance
    mem[8'hFF] = 8'h5A;
    mem[8'h00] = 8'hC3;
    @(negedge clock) start2 = 1'b1;
    @(negedge clock) start2 = 1'b0;
    done_cyc2 = -1;
    n_wr2 = 0;
    wr_run2 = 0;
    bad_len2 = 0;
    a2 = '{8'h00, 8'h00};
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clock);
      if (!bus2.wr) begin
        if (wr_run2 == 0) begin
          if (n_wr2 < 2) a2[n_wr2] = bus2.adout;
          n_wr2++;
        end
        wr_run2++;
      end else begin
        if (wr_run2 != 0 && wr_run2 != 2) bad_len2++;
        wr_run2 = 0;
      end
      if (done2) done_cyc2 = c;
    end
    check("wrap_latency", done_cyc2, 36);
    check("wrap_pulses", n_wr2, 2);
    check("wrap_wr_len_bad", bad_len2, 0);
    check("wrap_addr0", a2[0], 8'hFF);
    check("wrap_addr1", a2[1], 8'h00);
    check("wrap_rdata", rdata2, 16'hC35A);
    check("wrap_valid", valid2, 1);
    $display("wrap burst: addrs=%h,%h rdata=%h done_at=%0d", a2[0], a2[1], rdata2, done_cyc2);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
